// File: rtl/stopwatch_up_pkg.sv
// stopwatch_up_pkg: shared state encoding and digit constants for the stopwatch
package stopwatch_up_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
  localparam int DIGIT_W = 4;
  localparam int MOD10 = 10;
  localparam int MOD6 = 6;
endpackage

// File: rtl/stopwatch_up_if.sv
// stopwatch_up_if: command inputs and BCD time outputs of the stopwatch
interface stopwatch_up_if;
  import stopwatch_up_pkg::*;
  logic tick;
  logic start;
  logic stop;
  logic zero;
  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic running;
  logic full;
  logic carry;
  modport master (
    output tick, start, stop, zero,
    input sec_ones, sec_tens, min_ones, min_tens, running, full, carry
  );
  modport slave (
    input tick, start, stop, zero,
    output sec_ones, sec_tens, min_ones, min_tens, running, full, carry
  );
endinterface

// File: rtl/counter_up_modn.sv
// counter_up_modn: one BCD digit counting 0..modulus-1 with terminal-count output
module counter_up_modn
  import stopwatch_up_pkg::*;
#(
  parameter int modulus = 10
) (
  input  logic               clock,
  input  logic               clearn,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] digit,
  output logic               tc
);
  localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(modulus - 1);
  // clear wins over enable; an out-of-range value is forced to 0 on its next increment
  always_ff @(posedge clock or negedge clearn)
    if (!clearn) digit <= '0;
    else if (clr) digit <= '0;
    else if (en) digit <= (digit >= LAST) ? '0 : digit + 1'b1;
  assign tc = en & (digit == LAST);
endmodule

// File: rtl/stopwatch_up.sv
// stopwatch_up: saturating mm:ss BCD stopwatch with start/stop/zero control
module stopwatch_up
  import stopwatch_up_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic clock,
  input  logic clearn,
  stopwatch_up_if.slave sw
);
  localparam logic [DIGIT_W-1:0] MT = DIGIT_W'(MAX_MIN_TENS);
  state_t state;
  logic [DIGIT_W-1:0] so, st, mo, mt;
  logic so_tc, st_tc, mo_tc, unused_tc;
  logic at_max, hit_max, cnt_en;
  // at_max guards the count from ever wrapping, even if RUN is re-entered at the limit
  assign at_max = (mt == MT) & (mo == 4'd9) & (st == 4'd5) & (so == 4'd9);
  assign cnt_en = (state == RUN) & sw.tick & ~sw.zero & ~at_max;
  assign hit_max = cnt_en & (mt == MT) & (mo == 4'd9) & (st == 4'd5) & (so == 4'd8);
  counter_up_modn #(.modulus(MOD10)) u_so (.clock(clock), .clearn(clearn), .en(cnt_en), .clr(sw.zero), .digit(so), .tc(so_tc));
  counter_up_modn #(.modulus(MOD6))  u_st (.clock(clock), .clearn(clearn), .en(so_tc),  .clr(sw.zero), .digit(st), .tc(st_tc));
  counter_up_modn #(.modulus(MOD10)) u_mo (.clock(clock), .clearn(clearn), .en(st_tc),  .clr(sw.zero), .digit(mo), .tc(mo_tc));
  counter_up_modn #(.modulus(MOD6))  u_mt (.clock(clock), .clearn(clearn), .en(mo_tc),  .clr(sw.zero), .digit(mt), .tc(unused_tc));
  // control FSM: stop beats start, FULL only leaves on zero
  always_ff @(posedge clock or negedge clearn)
    if (!clearn) state <= IDLE;
    else
      case (state)
        IDLE: state <= (sw.start && !sw.stop) ? RUN : IDLE;
        RUN:  state <= sw.stop ? IDLE : (hit_max || (at_max && !sw.zero)) ? FULL : RUN;
        FULL: state <= sw.zero ? IDLE : FULL;
        default: state <= IDLE;
      endcase
  assign sw.sec_ones = so;
  assign sw.sec_tens = st;
  assign sw.min_ones = mo;
  assign sw.min_tens = mt;
  assign sw.running = (state == RUN);
  assign sw.full = (state == FULL);
  assign sw.carry = st_tc;
endmodule

// File: tb/tb_stopwatch_up.sv
// tb_stopwatch_up: table, directed and randomized checks against an integer-seconds model
module tb_stopwatch_up;
  logic clock = 1'b0;
  logic clearn = 1'b0;
  always #5 clock = ~clock;
  stopwatch_up_if if0 ();
  stopwatch_up_if if1 ();
  stopwatch_up #(.MAX_MIN_TENS(5)) dut0 (.clock(clock), .clearn(clearn), .sw(if0));
  stopwatch_up #(.MAX_MIN_TENS(0)) dut1 (.clock(clock), .clearn(clearn), .sw(if1));
  int n_cmp = 0;
  int n_bad = 0;
  int m_tot [2];
  bit m_run [2];
  bit m_full [2];
  typedef struct {
    bit t, s, p, z;
    int tot;
    bit run, full, c;
  } vec_t;
  vec_t tbl [13];

  function automatic logic [15:0] bcd(int v);
    return {4'(v / 600), 4'((v / 60) % 10), 4'((v % 60) / 10), 4'(v % 10)};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(int d, bit t, bit s, bit p, bit z);
    if0.tick = (d == 0) && t; if0.start = (d == 0) && s; if0.stop = (d == 0) && p; if0.zero = (d == 0) && z;
    if1.tick = (d == 1) && t; if1.start = (d == 1) && s; if1.stop = (d == 1) && p; if1.zero = (d == 1) && z;
  endtask

  task automatic outs(int d, output logic [15:0] dg, output logic r, output logic f, output logic c);
    if (d == 0) begin
      dg = {if0.min_tens, if0.min_ones, if0.sec_tens, if0.sec_ones}; r = if0.running; f = if0.full; c = if0.carry;
    end else begin
      dg = {if1.min_tens, if1.min_ones, if1.sec_tens, if1.sec_ones}; r = if1.running; f = if1.full; c = if1.carry;
    end
  endtask

  task automatic cyc(int d, bit t, bit s, bit p, bit z, output logic c_pre);
    logic [15:0] dg;
    logic r, f;
    drive(d, t, s, p, z);
    #1 outs(d, dg, r, f, c_pre);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(int d, string nm, int tot, bit run, bit full);
    logic [15:0] dg;
    logic r, f, c;
    outs(d, dg, r, f, c);
    check({nm, " digits"}, 32'(dg), 32'(bcd(tot)));
    check({nm, " running"}, 32'(r), 32'(run));
    check({nm, " full"}, 32'(f), 32'(full));
  endtask

  task automatic ticks(int d, int n);
    logic c;
    repeat (n) cyc(d, 1, 0, 0, 0, c);
  endtask

  task automatic model(int d, bit t, bit s, bit p, bit z, output bit c);
    int mx;
    mx = (d == 0) ? 3599 : 599;
    c = m_run[d] && t && !z && (m_tot[d] % 60 == 59) && (m_tot[d] < mx);
    if (z) m_tot[d] = 0;
    else if (m_run[d] && t && m_tot[d] < mx) m_tot[d]++;
    if (m_full[d]) begin
      if (z) m_full[d] = 0;
    end else if (m_run[d]) begin
      if (p) m_run[d] = 0;
      else if (m_tot[d] == mx) begin m_run[d] = 0; m_full[d] = 1; end
    end else if (s && !p) m_run[d] = 1;
  endtask

  initial begin
    logic c;
    logic [15:0] dg;
    logic r, f, cc;
    bit t, s, p, z, ce;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 2, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 3, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 4, 1, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 5, 1, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 5, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 5, 0, 0, 0};
    tbl[9]  = '{0, 1, 0, 0, 5, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 6, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 0, 0, 1, 1, 0, 0};
    drive(0, 0, 0, 0, 0);
    #2;
    outs(0, dg, r, f, cc);
    check("reset digits", 32'(dg), 32'h0);
    check("reset running", 32'(r), 32'h0);
    check("reset full", 32'(f), 32'h0);
    check("reset carry", 32'(cc), 32'h0);
    @(negedge clock) clearn = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc(0, tbl[i].t, tbl[i].s, tbl[i].p, tbl[i].z, c);
      check($sformatf("tbl%0d carry", i), 32'(c), 32'(tbl[i].c));
      chk(0, $sformatf("tbl%0d", i), tbl[i].tot, tbl[i].run, tbl[i].full);
    end
    ticks(0, 57);
    cyc(0, 1, 0, 0, 0, c);
    check("to59 carry", 32'(c), 32'h0);
    chk(0, "to59", 59, 1, 0);
    cyc(0, 1, 0, 0, 0, c);
    check("roll carry", 32'(c), 32'h1);
    chk(0, "roll", 60, 1, 0);
    cyc(0, 0, 0, 0, 0, c);
    check("after roll carry", 32'(c), 32'h0);
    ticks(0, 132);
    chk(0, "at0312", 192, 1, 0);
    cyc(0, 1, 0, 0, 1, c);
    check("zero tick carry", 32'(c), 32'h0);
    chk(0, "zero tick", 0, 1, 0);
    ticks(0, 1);
    chk(0, "after zero", 1, 1, 0);
    ticks(0, 149);
    chk(0, "at0230", 150, 1, 0);
    #2 clearn = 1'b0;
    #1 chk(0, "async rst", 0, 0, 0);
    outs(0, dg, r, f, cc);
    check("async rst carry", 32'(cc), 32'h0);
    #1 clearn = 1'b1;
    ticks(0, 3);
    chk(0, "post rst ticks", 0, 0, 0);
    cyc(0, 0, 1, 0, 0, c);
    ticks(0, 1);
    chk(0, "post rst start", 1, 1, 0);
    cyc(1, 0, 1, 0, 0, c);
    ticks(1, 598);
    chk(1, "at0958", 598, 1, 0);
    ticks(1, 1);
    chk(1, "sat", 599, 0, 1);
    ticks(1, 3);
    cyc(1, 0, 1, 0, 0, c);
    chk(1, "sat hold", 599, 0, 1);
    cyc(1, 0, 0, 0, 1, c);
    chk(1, "full zero", 0, 0, 0);
    @(negedge clock) clearn = 1'b0;
    #2 clearn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_tot[d] = 0; m_run[d] = 0; m_full[d] = 0;
    end
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 3000; n++) begin
        t = $urandom_range(0, 9) < 6;
        s = $urandom_range(0, 9) == 0;
        p = $urandom_range(0, 29) == 0;
        z = $urandom_range(0, 799) == 0;
        model(d, t, s, p, z, ce);
        cyc(d, t, s, p, z, c);
        check($sformatf("rnd%0d carry", d), 32'(c), 32'(ce));
        outs(d, dg, r, f, cc);
        check($sformatf("rnd%0d state", d), {14'h0, dg, r, f}, {14'h0, bcd(m_tot[d]), m_run[d], m_full[d]});
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
